// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } send_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    A    = 2'd1,
    B    = 2'd2
  } grant_t;

endpackage

// File: rtl/uart_tx_arbiter_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; accepts push+pop together when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; wraps modulo 2*DEPTH through the extra MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-client arbiter feeding a byte FIFO that paces writes into a uart_tx.
// Optional macro UART_TX_ARB_CRLF_EN: a queued LF is sent as CR then LF.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_wr,
  input  logic [BYTE_W-1:0] a_din,
  input  logic              a_lock,
  output logic              a_ready,
  input  logic              b_wr,
  input  logic [BYTE_W-1:0] b_din,
  input  logic              b_lock,
  output logic              b_ready,
  output logic              uart_wr,
  output logic [BYTE_W-1:0] uart_din,
  input  logic              uart_ready,
  output logic              idle
);

  grant_t            r_grant;
  grant_t            w_grant_nxt;
  send_state_t       r_state;
  send_state_t       w_state_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_send_cr;
  logic [BYTE_W-1:0] w_head;
  logic [BYTE_W-1:0] w_fifo_din;
  logic [BYTE_W-1:0] w_next_byte;
  logic [BYTE_W-1:0] r_din;

  assign a_ready    = !reset && (r_grant == A) && !w_full;
  assign b_ready    = !reset && (r_grant == B) && !w_full;
  assign w_push     = (a_wr && a_ready) || (b_wr && b_ready);
  assign w_fifo_din = (r_grant == A) ? a_din : b_din;

  assign uart_wr  = !reset && (r_state == ISSUE);
  assign uart_din = reset ? '0 : r_din;
  assign idle     = !reset && w_empty && (r_state == IDLE) && (r_grant == NONE);

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef UART_TX_ARB_CRLF_EN
  logic r_cr;

  // An LF head goes out as CR first; the flag remembers the CR was sent.
  assign w_send_cr   = (w_head == CHAR_LF) && !r_cr;
  assign w_next_byte = w_send_cr ? CHAR_CR : w_head;

  // CR flag: set by the CR issue, cleared by the following LF issue.
  always_ff @(posedge clk) begin
    if (reset)                 r_cr <= 1'b0;
    else if (r_state == ISSUE) r_cr <= w_send_cr;
  end
`else
  assign w_send_cr   = 1'b0;
  assign w_next_byte = w_head;
`endif

  // Grant and sender state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= NONE;
      r_state <= IDLE;
    end else begin
      r_grant <= w_grant_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Grant selection: A has priority from NONE; owner keeps it while wr or lock.
  always_comb begin
    w_grant_nxt = r_grant;
    case (r_grant)
      NONE: begin
        if (a_wr || a_lock)      w_grant_nxt = A;
        else if (b_wr || b_lock) w_grant_nxt = B;
      end
      A:       if (!(a_wr || a_lock)) w_grant_nxt = NONE;
      B:       if (!(b_wr || b_lock)) w_grant_nxt = NONE;
      default: w_grant_nxt = NONE;
    endcase
  end

  // Sender sequencing: one-cycle write pulse, one guard cycle, then wait for ready.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && uart_ready) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end
      end
      ISSUE: begin
        w_state_nxt = GUARD;
        w_pop       = !w_send_cr;
      end
      GUARD:   w_state_nxt = WAIT;
      WAIT:    if (uart_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output byte captured on entry to ISSUE and held until the next issue.
  always_ff @(posedge clk) begin
    if (reset)       r_din <= '0;
    else if (w_load) r_din <= w_next_byte;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle behavioural model plus directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_wr, a_lock, a_ready, b_wr, b_lock, b_ready;
  logic [7:0] a_din, b_din, uart_din;
  logic       uart_wr, uart_ready, idle;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_wr(a_wr), .a_din(a_din), .a_lock(a_lock), .a_ready(a_ready),
    .b_wr(b_wr), .b_din(b_din), .b_lock(b_lock), .b_ready(b_ready),
    .uart_wr(uart_wr), .uart_din(uart_din), .uart_ready(uart_ready),
    .idle(idle)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state: queued bytes, grant owner (0 none, 1 A, 2 B), sender timing.
  logic [7:0] m_q[$];
  int         m_grant;
  bit         m_launch, m_busy, m_cr;
  int         m_issue_cyc;
  logic [7:0] m_din;

  // Observation logs used by the directed scenarios.
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  int         apush_cyc[$];
  int         bpush_cyc[$];

  task automatic clear_logs();
    pulse_cyc.delete(); pulse_dat.delete(); apush_cyc.delete(); bpush_cyc.delete();
  endtask

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    logic       e_ra, e_rb, e_wr, e_idle, do_pop;
    logic [7:0] byte_out;
    cyc++;
    if (reset) begin
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_uart_wr", uart_wr, 0);
      check("rst_uart_din", uart_din, 0);
      check("rst_idle", idle, 0);
      m_q.delete();
      m_grant = 0; m_launch = 0; m_busy = 0; m_cr = 0; m_din = 8'h00;
    end else begin
      e_ra = (m_grant == 1) && (m_q.size() < DEPTH);
      e_rb = (m_grant == 2) && (m_q.size() < DEPTH);
      e_wr = m_launch;
      byte_out = m_din;
      do_pop = 0;
      if (m_launch && m_q.size() > 0) begin
        byte_out = m_q[0];
`ifdef UART_TX_ARB_CRLF_EN
        if (m_q[0] == LF && !m_cr) begin byte_out = CR; m_cr = 1; end
        else begin do_pop = 1; m_cr = 0; end
`else
        do_pop = 1;
`endif
      end
      e_idle = (m_q.size() == 0) && !m_busy && !m_launch && (m_grant == 0);
      check("a_ready", a_ready, e_ra);
      check("b_ready", b_ready, e_rb);
      check("uart_wr", uart_wr, e_wr);
      check("uart_din", uart_din, byte_out);
      check("idle", idle, e_idle);
      if (uart_wr === 1'b1) begin pulse_cyc.push_back(cyc); pulse_dat.push_back(uart_din); end
      if (a_wr && a_ready) apush_cyc.push_back(cyc);
      if (b_wr && b_ready) bpush_cyc.push_back(cyc);
      // Sender: issue, one guard cycle, then released by the first ready from issue+2.
      if (m_launch) begin
        m_launch = 0; m_busy = 1; m_issue_cyc = cyc; m_din = byte_out;
      end else if (m_busy) begin
        if (cyc >= m_issue_cyc + 2 && uart_ready) m_busy = 0;
      end else if (m_q.size() > 0 && uart_ready) begin
        m_launch = 1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (a_wr && e_ra) m_q.push_back(a_din);
      if (b_wr && e_rb) m_q.push_back(b_din);
      case (m_grant)
        0: m_grant = (a_wr || a_lock) ? 1 : ((b_wr || b_lock) ? 2 : 0);
        1: if (!(a_wr || a_lock)) m_grant = 0;
        default: if (!(b_wr || b_lock)) m_grant = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold wr with data until accepted or budget expires; wr is left high.
  task automatic push(input bit is_b, input logic [7:0] d, input int budget, output bit ok);
    ok = 0;
    if (is_b) begin b_wr = 1; b_din = d; end else begin a_wr = 1; a_din = d; end
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (is_b ? b_ready : a_ready) ok = 1;
      else tick();
    end
    if (ok) tick();
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (idle === 1'b1) seen = 1;
    end
    check("wait_idle", seen, 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit         ok;
  logic [7:0] exp_q[$];

  initial begin
    reset = 1; a_wr = 0; a_lock = 0; a_din = 0; b_wr = 0; b_lock = 0; b_din = 0; uart_ready = 1;
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    check("post_reset_idle", idle, 1);
    check("post_reset_uart_wr", uart_wr, 0);
    tick();

    // Two A bytes: latency 2 from first push, spacing 4.
    clear_logs();
    push(0, 8'h41, 10, ok); check("t1_push0", ok, 1);
    push(0, 8'h42, 10, ok); check("t1_push1", ok, 1);
    a_wr = 0;
    wait_idle(60);
    check("t1_npulse", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2 && apush_cyc.size() == 2) begin
      check("t1_byte0", pulse_dat[0], 8'h41);
      check("t1_byte1", pulse_dat[1], 8'h42);
      check("t1_latency", pulse_cyc[0] - apush_cyc[0], 2);
      check("t1_spacing", pulse_cyc[1] - pulse_cyc[0], 4);
    end

    // Simultaneous requests: A wins, B waits until A releases.
    clear_logs();
    a_wr = 1; a_din = 8'h51; b_wr = 1; b_din = 8'h61;
    push(0, 8'h51, 10, ok); push(0, 8'h52, 10, ok); push(0, 8'h53, 10, ok);
    a_wr = 0;
    push(1, 8'h61, 20, ok); check("t2_bpush", ok, 1);
    push(1, 8'h62, 20, ok);
    b_wr = 0;
    wait_idle(80);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h61, 8'h62};
    check("t2_npulse", pulse_dat.size(), exp_q.size());
    if (pulse_dat.size() == exp_q.size())
      foreach (exp_q[i]) check("t2_order", pulse_dat[i], exp_q[i]);
    if (apush_cyc.size() == 3 && bpush_cyc.size() > 0)
      check("t2_handover", bpush_cyc[0] - apush_cyc[2], 3);

    // Locked 20-byte B burst with A requesting mid-burst.
    clear_logs();
    b_lock = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a_wr = 1; a_din = 8'h11; end
      push(1, 8'(8'h80 + i), 40, ok);
      check("t3_bpush", ok, 1);
    end
    b_wr = 0; b_lock = 0;
    push(0, 8'h11, 200, ok); check("t3_apush", ok, 1);
    push(0, 8'h12, 20, ok);
    a_wr = 0;
    wait_idle(300);
    check("t3_npulse", pulse_dat.size(), 22);
    if (pulse_dat.size() == 22) begin
      for (int i = 0; i < 20; i++) check("t3_burst", pulse_dat[i], 8'(8'h80 + i));
      check("t3_a0", pulse_dat[20], 8'h11);
      check("t3_a1", pulse_dat[21], 8'h12);
    end

    // Fill to DEPTH with the uart stalled; the 17th byte is refused.
    clear_logs();
    uart_ready = 0;
    for (int i = 0; i < 17; i++) begin
      push(1, 8'(8'hC0 + i), 8, ok);
      check("t4_accept", ok, (i < 16) ? 1 : 0);
    end
    @(negedge clk);
    check("t4_full_ready", b_ready, 0);
    tick();
    b_wr = 0;
    repeat (3) tick();
    check("t4_no_tx_stalled", pulse_dat.size(), 0);
    uart_ready = 1;
    wait_idle(200);
    check("t4_npulse", pulse_dat.size(), 16);
    if (pulse_dat.size() == 16) check("t4_last", pulse_dat[15], 8'hCF);

    // Reset while waiting on the uart with 5 bytes queued.
    clear_logs();
    uart_ready = 0;
    for (int i = 0; i < 6; i++) push(0, 8'(8'hE0 + i), 8, ok);
    a_wr = 0;
    repeat (2) tick();
    uart_ready = 1; tick(); uart_ready = 0;
    repeat (5) tick();
    check("t5_one_issued", pulse_dat.size(), 1);
    reset = 1; repeat (2) tick(); reset = 0;
    clear_logs();
    uart_ready = 1;
    @(negedge clk);
    check("t5_rel_uart_wr", uart_wr, 0);
    check("t5_rel_idle", idle, 1);
    tick();
    repeat (30) tick();
    check("t5_no_tx", pulse_dat.size(), 0);

    // LF handling, with and without CR insertion.
    clear_logs();
    push(0, 8'h31, 10, ok); push(0, LF, 10, ok);
    a_wr = 0;
    wait_idle(60);
`ifdef UART_TX_ARB_CRLF_EN
    exp_q = '{8'h31, 8'h0D, 8'h0A};
`else
    exp_q = '{8'h31, 8'h0A};
`endif
    check("t6_npulse", pulse_dat.size(), exp_q.size());
    if (pulse_dat.size() == exp_q.size())
      foreach (exp_q[i]) check("t6_seq", pulse_dat[i], exp_q[i]);

    // Random traffic, locks, stalls and occasional resets against the model.
    for (int n = 0; n < 1500; n++) begin
      a_wr  = ($urandom_range(0, 9) < 3);
      b_wr  = ($urandom_range(0, 9) < 3);
      a_din = 8'($urandom);
      b_din = ($urandom_range(0, 7) == 0) ? LF : 8'($urandom);
      if ($urandom_range(0, 19) == 0) a_lock = ~a_lock;
      if ($urandom_range(0, 19) == 0) b_lock = ~b_lock;
      uart_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; a_wr = 0; b_wr = 0; a_lock = 0; b_lock = 0; uart_ready = 1;
    wait_idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
